spi_shift_engine: RTL

// - SPI master serialiser/deserialiser that sits directly downstream of spi_controller.
// - Takes a start strobe, TX word and frame config from the controller's registers.
// - Generates SCLK, MOSI and CS_N, samples MISO, and returns the RX word plus a done pulse.
// - The done pulse feeds the controller's status/IRQ logic.

---
 rtl/spi_shift_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   SPI master serialiser/deserialiser driven by spi_controller. Accepts a
//   start strobe with a TX word and frame configuration, generates CS_N,
//   SCLK and MOSI, samples MISO, and returns the RX word with a done pulse.
//
// Parameters
//   DIV_W   width of i_clk_div; SCLK half-period = i_clk_div+1 clk cycles
//   DATA_W  TX/RX word width (frames of 8..32 bits)
//
// Ports
//   FCLK_CLK0    in   clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   i_start      in   start strobe, honoured only in IDLE
//   i_tx_data    in   transmit word, latched on accepted start
//   i_num_bytes  in   frame length in bytes minus 1, latched on start
//   i_clk_div    in   half-period divider, latched on start
//   i_cpol       in   SCLK idle level
//   i_cpha       in   0: sample leading edge, 1: sample trailing edge
//   i_lsb_first  in   1: LSB shifted first
//   o_busy       out  transfer in progress
//   o_done       out  one-cycle end-of-transfer pulse
//   o_rx_data    out  received word, valid from o_done onward
//   o_cs_n       out  active-low chip select
//   o_sclk       out  SPI clock
//   o_mosi       out  serial data out
//   i_miso       in   serial data in
//
// Build option
//   SPI_LOOPBACK_EN  when defined, MISO samples come from the registered
//                    MOSI and i_miso is ignored.

module spi_shift_engine #(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              FCLK_CLK0,
  input  logic              reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [1:0]        i_num_bytes,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_cs_n,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int EDGE_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx;
  logic [1:0]        r_nb;
  logic [DIV_W-1:0]  r_div;
  logic              r_cpha;
  logic              r_lsb;
  logic [DIV_W-1:0]  r_hp_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic              r_busy;
  logic              r_done;
  logic              r_cs_n;
  logic              r_sclk;
  logic              r_mosi;

  logic              w_hp_exp;
  logic              w_last_edge;
  logic [IDX_W-1:0]  w_k;
  logic              w_miso;
  logic              w_busy_nxt;

`ifdef SPI_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = i_miso;
  assign w_miso        = r_mosi;
`else
  assign w_miso = i_miso;
`endif

  // Position in the word of the k-th bit on the wire for the given order.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] k,
                                               input logic             lsb,
                                               input logic [1:0]       nb);
    logic [IDX_W-1:0] last;
    last = IDX_W'({nb, 3'b111});
    return lsb ? k : (last - k);
  endfunction

  // r_edge counts SCLK edges already produced: even = next edge is leading.
  always_comb begin
    w_hp_exp    = (r_hp_cnt == r_div);
    w_last_edge = (r_edge == EDGE_W'({r_nb, 4'b1111}));
    w_k         = r_edge[EDGE_W-1:1];
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SETUP;
      S_SETUP: if (w_hp_exp) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_hp_exp && w_last_edge) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hp_exp) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) ||
                 (w_state_nxt == S_HOLD);
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (reset) begin
      r_tx     <= '0;
      r_rx_sh  <= '0;
      r_rx     <= '0;
      r_nb     <= '0;
      r_div    <= '0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
      r_hp_cnt <= '0;
      r_edge   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cs_n <= ~w_busy_nxt;
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          r_sclk   <= i_cpol;
          r_hp_cnt <= '0;
          if (i_start) begin
            r_tx    <= i_tx_data;
            r_nb    <= i_num_bytes;
            r_div   <= i_clk_div;
            r_cpha  <= i_cpha;
            r_lsb   <= i_lsb_first;
            r_edge  <= '0;
            r_rx_sh <= '0;
            r_mosi  <= i_tx_data[bit_pos('0, i_lsb_first, i_num_bytes)];
          end
        end
        S_SETUP: begin
          r_hp_cnt <= w_hp_exp ? '0 : r_hp_cnt + 1'b1;
        end
        S_SHIFT: begin
          r_hp_cnt <= w_hp_exp ? '0 : r_hp_cnt + 1'b1;
          if (w_hp_exp) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            if (!r_edge[0]) begin
              // Leading edge: CPHA=1 re-presents the current bit (bit 0 first).
              if (r_cpha) r_mosi <= r_tx[bit_pos(w_k, r_lsb, r_nb)];
              else        r_rx_sh[bit_pos(w_k, r_lsb, r_nb)] <= w_miso;
            end else begin
              if (r_cpha)            r_rx_sh[bit_pos(w_k, r_lsb, r_nb)] <= w_miso;
              else if (!w_last_edge) r_mosi <= r_tx[bit_pos(w_k + 1'b1, r_lsb, r_nb)];
            end
          end
        end
        S_HOLD: begin
          r_hp_cnt <= w_hp_exp ? '0 : r_hp_cnt + 1'b1;
          if (w_hp_exp) r_rx <= r_rx_sh;
        end
        S_DONE: begin
          r_hp_cnt <= '0;
        end
        default: begin
          r_hp_cnt <= '0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx;
  assign o_cs_n    = r_cs_n;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;

endmodule
